apb_stream_bridge: RTL and testbench

- 32-bit APB slave sitting directly downstream of the 16-to-32 APB upsizer.
- Converts register accesses into valid/ready streams to and from the crypto core: an input FIFO feeds the core, an output FIFO collects its results.
- Merges the split half-word writes produced by the upsizer into full 32-bit words before pushing them.

---
 rtl/apb_stream_bridge.sv | 238 +++++++++++++++++++++++
 tb/tb_apb_stream_bridge.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_stream_bridge.sv
// APB slave that turns register accesses into valid/ready streams to and from the crypto core.
// Build option APB_STREAM_BRIDGE_IRQ_EN adds a registered interrupt and a sticky error flag.
module apb_stream_bridge #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic        pclk,
    input  logic        prst,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    input  logic [3:0]  pstrb_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic [31:0] din_data_o,
    output logic        din_valid_o,
    input  logic        din_ready_i,
    input  logic [31:0] dout_data_i,
    input  logic        dout_valid_i,
    output logic        dout_ready_o,
    output logic        irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_DIN    = 3'd2;
    localparam logic [2:0] REG_PEEK   = 3'd3;
    localparam logic [2:0] REG_POP    = 3'd4;

    logic [31:0]   inMem_q  [DEPTH];
    logic [31:0]   outMem_q [DEPTH];
    logic [PW-1:0] inWp_q, inWp_d, inRp_q, inRp_d;
    logic [PW-1:0] outWp_q, outWp_d, outRp_q, outRp_d;
    logic [31:0]   hold_q, hold_d;
    logic          partial_q, partial_d;
    logic          irqEn_q, irqEn_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic [PW-1:0] inCount, outCount, outCountNext;
    logic [7:0]    inCnt8, outCnt8;
    logic          inEmpty, inFull, outEmpty, outFull;
    logic          corePop, corePush;
    logic [2:0]    regSel;
    logic          accessPh, dinPushReq, popReq, stall, timeoutHit;
    logic          complete, okDone, errDone;
    logic          wrCtrl, wrDin, clrFifo, inPush, outPop;
    logic [31:0]   merged, outHead, outPeek, readData;
    logic          errSticky;
    logic          unusedAddr;

    assign regSel     = paddr_i[4:2];
    assign unusedAddr = ^{paddr_i[31:5], paddr_i[1:0]};

    assign inCount  = inWp_q - inRp_q;
    assign outCount = outWp_q - outRp_q;
    assign inCnt8   = 8'(inCount);
    assign outCnt8  = 8'(outCount);
    assign inEmpty  = (inWp_q == inRp_q);
    assign outEmpty = (outWp_q == outRp_q);
    assign inFull   = (inWp_q[AW] != inRp_q[AW]) && (inWp_q[AW-1:0] == inRp_q[AW-1:0]);
    assign outFull  = (outWp_q[AW] != outRp_q[AW]) && (outWp_q[AW-1:0] == outRp_q[AW-1:0]);

    assign din_valid_o  = prst && !inEmpty;
    assign din_data_o   = inEmpty ? 32'h0 : inMem_q[inRp_q[AW-1:0]];
    assign dout_ready_o = prst && !outFull;
    assign corePop      = din_valid_o && din_ready_i;
    assign corePush     = dout_valid_i && dout_ready_o;

    // A full or empty FIFO only stalls when the core is not freeing space or supplying data this cycle.
    assign accessPh   = psel_i && penable_i;
    assign dinPushReq = accessPh && pwrite_i && (regSel == REG_DIN) && pstrb_i[3];
    assign popReq     = accessPh && !pwrite_i && (regSel == REG_POP);
    assign stall      = (dinPushReq && inFull && !corePop) || (popReq && outEmpty && !corePush);
    assign timeoutHit = stall && (tcnt_q == TW'(TIMEOUT - 1));
    assign complete   = accessPh && (!stall || timeoutHit);
    assign okDone     = complete && !timeoutHit;
    assign errDone    = timeoutHit;

    assign wrCtrl  = okDone && pwrite_i && (regSel == REG_CTRL);
    assign wrDin   = okDone && pwrite_i && (regSel == REG_DIN);
    assign clrFifo = wrCtrl && pwdata_i[0];
    assign inPush  = wrDin && pstrb_i[3];
    assign outPop  = okDone && popReq;

    assign pready_o  = prst && complete;
    assign pslverr_o = prst && errDone;
    assign prdata_o  = (prst && okDone && !pwrite_i) ? readData : 32'h0;

    // An empty output FIFO forwards the core word so a waiting pop finishes in the cycle it arrives.
    assign outHead = outEmpty ? dout_data_i : outMem_q[outRp_q[AW-1:0]];
    assign outPeek = outEmpty ? 32'h0 : outMem_q[outRp_q[AW-1:0]];

    always_comb begin
        merged = hold_q;
        for (int b = 0; b < 4; b++) begin
            if (pstrb_i[b]) begin
                merged[8*b +: 8] = pwdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        readData = 32'h0;
        case (regSel)
            REG_CTRL:   readData = {30'h0, irqEn_q, 1'b0};
            REG_STATUS: readData = {12'h0, errSticky, partial_q, outEmpty, inFull, outCnt8, inCnt8};
            REG_PEEK:   readData = outPeek;
            REG_POP:    readData = outHead;
            default:    readData = 32'h0;
        endcase
    end

    always_comb begin
        inWp_d    = inWp_q;
        inRp_d    = inRp_q;
        outWp_d   = outWp_q;
        outRp_d   = outRp_q;
        hold_d    = hold_q;
        partial_d = partial_q;
        irqEn_d   = irqEn_q;
        if (inPush) begin
            inWp_d = inWp_q + PW'(1);
        end
        if (corePop) begin
            inRp_d = inRp_q + PW'(1);
        end
        if (corePush) begin
            outWp_d = outWp_q + PW'(1);
        end
        if (outPop) begin
            outRp_d = outRp_q + PW'(1);
        end
        if (wrDin) begin
            if (pstrb_i[3]) begin
                hold_d    = 32'h0;
                partial_d = 1'b0;
            end else begin
                hold_d    = merged;
                partial_d = partial_q || (|pstrb_i);
            end
        end
        if (wrCtrl) begin
            irqEn_d = pwdata_i[1];
        end
        // Clear overrides any core traffic in the same cycle.
        if (clrFifo) begin
            inWp_d    = '0;
            inRp_d    = '0;
            outWp_d   = '0;
            outRp_d   = '0;
            hold_d    = 32'h0;
            partial_d = 1'b0;
        end
    end

    assign outCountNext = outWp_d - outRp_d;

    always_comb begin
        tcnt_d = tcnt_q;
        if (!accessPh || complete) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (inPush) begin
            inMem_q[inWp_q[AW-1:0]] <= merged;
        end
        if (corePush) begin
            outMem_q[outWp_q[AW-1:0]] <= dout_data_i;
        end
    end

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            inWp_q    <= '0;
            inRp_q    <= '0;
            outWp_q   <= '0;
            outRp_q   <= '0;
            hold_q    <= 32'h0;
            partial_q <= 1'b0;
            irqEn_q   <= 1'b0;
            tcnt_q    <= '0;
        end else begin
            inWp_q    <= inWp_d;
            inRp_q    <= inRp_d;
            outWp_q   <= outWp_d;
            outRp_q   <= outRp_d;
            hold_q    <= hold_d;
            partial_q <= partial_d;
            irqEn_q   <= irqEn_d;
            tcnt_q    <= tcnt_d;
        end
    end

`ifdef APB_STREAM_BRIDGE_IRQ_EN
    logic errSticky_q, errSticky_d;
    logic irq_q, irq_d;

    always_comb begin
        errSticky_d = errSticky_q;
        if (wrCtrl && pwdata_i[2]) begin
            errSticky_d = 1'b0;
        end
        if (errDone) begin
            errSticky_d = 1'b1;
        end
        irq_d = irqEn_d && ((outCountNext != '0) || errSticky_d);
    end

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            errSticky_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            errSticky_q <= errSticky_d;
            irq_q       <= irq_d;
        end
    end

    assign errSticky = errSticky_q;
    assign irq_o     = irq_q;
`else
    logic unusedIrq;
    assign unusedIrq = ^outCountNext;
    assign errSticky = 1'b0;
    assign irq_o     = 1'b0;
`endif

endmodule

// File: tb/tb_apb_stream_bridge.sv
// Directed bench for apb_stream_bridge: APB register traffic against hand-computed expectations.
module tb_apb_stream_bridge;
   logic        pclk = 1'b0;
   logic        prst;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [31:0] din_data;
   logic        din_valid, din_ready;
   logic [31:0] dout_data;
   logic        dout_valid, dout_ready;
   logic        irq;

   int          passCount = 0;
   int          checkCount = 0;
   logic [31:0] rdata;
   logic        err;
   int          waited;
   logic        sawEarly;

   apb_stream_bridge #(.DEPTH(8), .TIMEOUT(64)) dut (
      .pclk         (pclk),
      .prst         (prst),
      .psel_i       (psel),
      .penable_i    (penable),
      .pwrite_i     (pwrite),
      .paddr_i      (paddr),
      .pwdata_i     (pwdata),
      .pstrb_i      (pstrb),
      .prdata_o     (prdata),
      .pready_o     (pready),
      .pslverr_o    (pslverr),
      .din_data_o   (din_data),
      .din_valid_o  (din_valid),
      .din_ready_i  (din_ready),
      .dout_data_i  (dout_data),
      .dout_valid_i (dout_valid),
      .dout_ready_o (dout_ready),
      .irq_o        (irq)
   );

   // 100 MHz clock
   always #5 pclk = ~pclk;

   // Hard stop in case a wait outside the bounded tasks ever hangs
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected done");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare a 32-bit value and count the result
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
   endtask

   // Compare a single bit and count the result
   task automatic checkBit(input string tag, input logic observed, input logic expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
   endtask

   // Drive an APB setup phase then enter the first access cycle
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb);
      @(posedge pclk);
      #1;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = data;
      pstrb   = strb;
      @(posedge pclk);
      #1;
      penable = 1'b1;
   endtask

   // Wait (bounded) for pready, capture the response, then return the bus to idle
   task automatic apbWait(input string tag, input int maxCycles, output logic [31:0] rd,
                          output logic er, output int wt);
      wt = 0;
      @(negedge pclk);
      while (!pready && wt < maxCycles) begin
         @(negedge pclk);
         wt++;
      end
      checkBit({tag, " done"}, pready, 1'b1);
      rd = prdata;
      er = pslverr;
      @(posedge pclk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
   endtask

   task automatic apbWrite(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
      logic [31:0] rdLocal;
      logic        erLocal;
      int          wtLocal;
      applyStimulus(1'b1, addr, data, strb);
      apbWait(tag, 100, rdLocal, erLocal, wtLocal);
   endtask

   task automatic apbRead(input string tag, input logic [31:0] addr, output logic [31:0] rd,
                          output int wt);
      logic erLocal;
      applyStimulus(1'b0, addr, 32'h0, 4'h0);
      apbWait(tag, 100, rd, erLocal, wt);
   endtask

   // Single-cycle core pop from the input FIFO
   task automatic corePopPulse();
      din_ready = 1'b1;
      @(posedge pclk);
      #1;
      din_ready = 1'b0;
   endtask

   initial begin
      prst = 1'b0;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
      din_ready = 1'b0; dout_data = 32'h0; dout_valid = 1'b0;

      // Outputs held at zero while reset is asserted
      repeat (2) @(negedge pclk);
      checkBit("reset pready", pready, 1'b0);
      checkBit("reset pslverr", pslverr, 1'b0);
      checkBit("reset din_valid", din_valid, 1'b0);
      checkBit("reset dout_ready", dout_ready, 1'b0);
      checkBit("reset irq", irq, 1'b0);
      checkOutput("reset prdata", prdata, 32'h0);
      prst = 1'b1;
      @(negedge pclk);
      checkBit("dout_ready after release", dout_ready, 1'b1);
      apbRead("status reset", 32'h04, rdata, waited);
      checkOutput("status reset", rdata, 32'h0002_0000);

      // Split half-word writes merge into one word
      apbWrite("din low half", 32'h08, 32'h0000_6689, 4'b0011);
      checkBit("no push on low half", din_valid, 1'b0);
      apbRead("status partial", 32'h04, rdata, waited);
      checkOutput("status partial", rdata, 32'h0006_0000);
      apbWrite("din high half", 32'h08, 32'h6677_0000, 4'b1100);
      checkBit("split din_valid", din_valid, 1'b1);
      checkOutput("split din_data", din_data, 32'h6677_6689);
      apbRead("status split", 32'h04, rdata, waited);
      checkOutput("status split", rdata, 32'h0002_0001);
      corePopPulse();
      checkBit("din_valid after pop", din_valid, 1'b0);

      // Fill the input FIFO, then a ninth push stalls until the core frees a slot
      for (int i = 0; i < 8; i++) begin
         apbWrite("fill", 32'h08, 32'h1000_0000 + 32'(i), 4'hF);
      end
      apbRead("status full", 32'h04, rdata, waited);
      checkOutput("status full", rdata, 32'h0003_0008);
      applyStimulus(1'b1, 32'h08, 32'hAAAA_0009, 4'hF);
      @(negedge pclk);
      checkBit("ninth write stalls", pready, 1'b0);
      @(negedge pclk);
      checkBit("ninth write still stalled", pready, 1'b0);
      din_ready = 1'b1;
      #1;
      checkBit("ninth write completes on pop", pready, 1'b1);
      checkBit("ninth write no error", pslverr, 1'b0);
      @(posedge pclk);
      #1;
      din_ready = 1'b0;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      checkOutput("head after stall pop", din_data, 32'h1000_0001);
      apbRead("status after stall", 32'h04, rdata, waited);
      checkOutput("status after stall", rdata, 32'h0003_0008);

      // Drain five, leave three queued plus a partial hold word
      din_ready = 1'b1;
      repeat (5) @(posedge pclk);
      #1;
      din_ready = 1'b0;
      checkOutput("head after drain", din_data, 32'h1000_0006);
      apbWrite("din partial byte", 32'h08, 32'h0000_00AB, 4'b0001);
      apbRead("status before clear", 32'h04, rdata, waited);
      checkOutput("status before clear", rdata, 32'h0006_0003);

      // CLR while the core is popping: everything empties
      din_ready = 1'b1;
      apbWrite("ctrl clear", 32'h00, 32'h0000_0001, 4'hF);
      checkBit("din_valid after clear", din_valid, 1'b0);
      din_ready = 1'b0;
      apbRead("status after clear", 32'h04, rdata, waited);
      checkOutput("status after clear", rdata, 32'h0002_0000);
      apbRead("ctrl readback clr", 32'h00, rdata, waited);
      checkOutput("ctrl readback clr", rdata, 32'h0);
      apbWrite("din top byte", 32'h08, 32'hCC00_0000, 4'b1000);
      checkOutput("hold was cleared", din_data, 32'hCC00_0000);
      corePopPulse();

      // Peek on an empty output FIFO is zero-wait and returns zero
      apbRead("peek empty", 32'h0C, rdata, waited);
      checkOutput("peek empty data", rdata, 32'h0);
      checkOutput("peek empty wait", 32'(waited), 32'd0);

      // Pop on empty stalls until the core supplies a word
      applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
      sawEarly = 1'b0;
      repeat (5) begin
         @(negedge pclk);
         if (pready) sawEarly = 1'b1;
      end
      checkBit("empty pop stalls", sawEarly, 1'b0);
      @(posedge pclk);
      #1;
      dout_data  = 32'h9999_8888;
      dout_valid = 1'b1;
      @(negedge pclk);
      checkBit("empty pop completes", pready, 1'b1);
      checkOutput("empty pop data", prdata, 32'h9999_8888);
      checkBit("empty pop no error", pslverr, 1'b0);
      @(posedge pclk);
      #1;
      dout_valid = 1'b0;
      psel = 1'b0; penable = 1'b0;
      apbRead("status after bypass", 32'h04, rdata, waited);
      checkOutput("status after bypass", rdata, 32'h0002_0000);

      // Two core results, peek then pop both in order
      dout_data  = 32'h1234_5678;
      dout_valid = 1'b1;
      @(posedge pclk);
      #1;
      dout_data = 32'h9ABC_DEF0;
      @(posedge pclk);
      #1;
      dout_valid = 1'b0;
      apbRead("status two results", 32'h04, rdata, waited);
      checkOutput("status two results", rdata, 32'h0000_0200);
      apbRead("peek head", 32'h0C, rdata, waited);
      checkOutput("peek head", rdata, 32'h1234_5678);
      apbRead("pop first", 32'h10, rdata, waited);
      checkOutput("pop first", rdata, 32'h1234_5678);
      checkOutput("pop first wait", 32'(waited), 32'd0);
      apbRead("pop second", 32'h10, rdata, waited);
      checkOutput("pop second", rdata, 32'h9ABC_DEF0);
      apbRead("status drained", 32'h04, rdata, waited);
      checkOutput("status drained", rdata, 32'h0002_0000);

      // IRQ_EN readback, unmapped offsets are inert
      apbWrite("ctrl irq_en", 32'h00, 32'h0000_0002, 4'hF);
      apbRead("ctrl readback", 32'h00, rdata, waited);
      checkOutput("ctrl readback", rdata, 32'h0000_0002);
      apbWrite("unmapped write", 32'h1C, 32'hFFFF_FFFF, 4'hF);
      apbRead("unmapped read", 32'h1C, rdata, waited);
      checkOutput("unmapped read", rdata, 32'h0);
      checkOutput("unmapped wait", 32'(waited), 32'd0);
      checkBit("irq tied low", irq, 1'b0);

      // Pop with no data times out on the 64th stalled cycle
      applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
      apbWait("timeout", 100, rdata, err, waited);
      checkBit("timeout pslverr", err, 1'b1);
      checkOutput("timeout prdata", rdata, 32'h0);
      checkOutput("timeout stall cycles", 32'(waited), 32'd63);

      // Dropping psel mid-stall clears the counter
      applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
      repeat (10) @(posedge pclk);
      #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk);
      applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
      apbWait("after abort", 100, rdata, err, waited);
      checkBit("after abort pslverr", err, 1'b1);
      checkOutput("after abort stall cycles", 32'(waited), 32'd63);

      // Reset asserted during a stalled push
      for (int i = 0; i < 8; i++) begin
         apbWrite("refill", 32'h08, 32'h2000_0000 + 32'(i), 4'hF);
      end
      applyStimulus(1'b1, 32'h08, 32'h2000_0008, 4'hF);
      @(negedge pclk);
      checkBit("refill ninth stalls", pready, 1'b0);
      prst = 1'b0;
      #1;
      checkBit("mid-stall reset pready", pready, 1'b0);
      checkBit("mid-stall reset din_valid", din_valid, 1'b0);
      checkBit("mid-stall reset dout_ready", dout_ready, 1'b0);
      checkBit("mid-stall reset pslverr", pslverr, 1'b0);
      checkOutput("mid-stall reset prdata", prdata, 32'h0);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(negedge pclk);
      prst = 1'b1;
      apbRead("status after reset", 32'h04, rdata, waited);
      checkOutput("status after reset", rdata, 32'h0002_0000);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
